// File: rtl/serial_negate_ctrl_if.sv
// serial_negate_ctrl_if: word-level request/result bundle for the serial negator
//   master drives start, neg_en, din; slave returns busy, done, dout, ovf, zero
interface serial_negate_ctrl_if #(parameter int WIDTH = 8);
   logic             start;
   logic             neg_en;
   logic [WIDTH-1:0] din;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] dout;
   logic             ovf;
   logic             zero;
   modport master(output start, neg_en, din, input busy, done, dout, ovf, zero);
   modport slave(input start, neg_en, din, output busy, done, dout, ovf, zero);
endinterface

// File: rtl/serial_negate_ctrl.sv
// serial_negate_ctrl: sequences an LSB-first bit-serial two's-complement negator over WIDTH-bit words
//   clk     system clock
//   rst     asynchronous active-high reset
//   io      slave side of serial_negate_ctrl_if (start/neg_en/din in; busy/done/dout/ovf/zero out)
module serial_negate_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_negate_ctrl_if.slave   io
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] src, res, dout_q;
   logic [CNT_W-1:0] cnt;
   logic             neg_q, seen_one, ovf_p, zero_p, ovf_q, zero_q, done_q;
   logic             y;
   // Mealy complement stage: bits pass unchanged up to and including the first 1, inverted after it
   assign y = (neg_q & seen_one) ? ~src[0] : src[0];
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;
   always_comb begin
      state_n = state;
      state_n = (state == IDLE)  ? (io.start ? SHIFT : IDLE) :
                (state == SHIFT) ? ((cnt == CNT_W'(WIDTH - 1)) ? DONE : SHIFT) :
                                   IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src      <= '0;
         res      <= '0;
         cnt      <= '0;
         neg_q    <= 1'b0;
         seen_one <= 1'b0;
         ovf_p    <= 1'b0;
         zero_p   <= 1'b0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // done is registered so it rises together with the freshly loaded dout
         done_q <= state == DONE;
         if (state == IDLE && io.start) begin
            src      <= io.din;
            neg_q    <= io.neg_en;
            seen_one <= 1'b0;
            cnt      <= '0;
            ovf_p    <= io.neg_en && io.din == {1'b1, {(WIDTH - 1){1'b0}}};
            zero_p   <= io.din == '0;
         end
         if (state == SHIFT) begin
            seen_one <= seen_one | src[0];
            res      <= {y, res[WIDTH-1:1]};
            src      <= src >> 1;
            cnt      <= cnt + CNT_W'(1);
         end
         if (state == DONE) begin
            dout_q <= res;
            ovf_q  <= ovf_p;
            zero_q <= zero_p;
         end
      end
   end
   assign io.busy = state != IDLE;
   assign io.done = done_q;
   assign io.dout = dout_q;
   assign io.ovf  = ovf_q;
   assign io.zero = zero_q;
endmodule

// File: tb/tb_serial_negate_ctrl.sv
// tb_serial_negate_ctrl: directed and exhaustive checks of serial_negate_ctrl against a cycle-level word model
module tb_serial_negate_ctrl;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   serial_negate_ctrl_if #(.WIDTH(W)) bus();
   serial_negate_ctrl #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .io(bus));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask
   // Word model: counts edges since the last accepted start; a start is accepted only
   // when no word is in flight (WIDTH+2 edges after the previous accept)
   int         since = -1;
   logic       l_start = 1'b0, l_neg = 1'b0;
   logic [W-1:0] l_din = '0;
   logic [W-1:0] e_dout = '0, p_dout = '0;
   logic       e_ovf = 1'b0, e_zero = 1'b0, p_ovf = 1'b0, p_zero = 1'b0;
   logic       e_busy, e_done;
   always @(negedge clk) begin
      if (rst) begin
         since   = -1;
         e_dout  = '0;
         e_ovf   = 1'b0;
         e_zero  = 1'b0;
         l_start = 1'b0;
      end else begin
         if (since >= 0 && since < 1000) since++;
         if ((since < 0 || since >= W + 2) && l_start) begin
            since  = 0;
            p_dout = l_neg ? W'((1 << W) - int'(l_din)) : l_din;
            p_ovf  = l_neg && int'(l_din) == (1 << (W - 1));
            p_zero = l_din == '0;
         end
         e_busy = since >= 0 && since <= W;
         e_done = since == W + 1;
         if (e_done) begin
            e_dout = p_dout;
            e_ovf  = p_ovf;
            e_zero = p_zero;
         end
         chk("busy", 32'(bus.busy), 32'(e_busy));
         chk("done", 32'(bus.done), 32'(e_done));
         chk("dout", 32'(bus.dout), 32'(e_dout));
         chk("ovf", 32'(bus.ovf), 32'(e_ovf));
         chk("zero", 32'(bus.zero), 32'(e_zero));
         l_start = bus.start;
         l_neg   = bus.neg_en;
         l_din   = bus.din;
      end
   end
   task automatic run_word(input logic neg, input logic [W-1:0] d, input logic [W-1:0] ed,
                           input logic eo, input logic ez);
      int edges = 0;
      int nbusy = 0;
      @(posedge clk);
      #2 bus.start = 1'b1; bus.neg_en = neg; bus.din = d;
      @(posedge clk);
      #2 bus.start = 1'b0; bus.neg_en = ~neg; bus.din = ~d;
      forever begin
         @(negedge clk);
         if (bus.busy) nbusy++;
         if (bus.done || edges > 4 * W) break;
         @(posedge clk);
         edges++;
      end
      chk("latency", 32'(edges), 32'(W + 1));
      chk("busy_len", 32'(nbusy), 32'(W + 1));
      chk("word_dout", 32'(bus.dout), 32'(ed));
      chk("word_ovf", 32'(bus.ovf), 32'(eo));
      chk("word_zero", 32'(bus.zero), 32'(ez));
   endtask
   initial begin
      int ndone;
      bus.start = 1'b0;
      bus.neg_en = 1'b0;
      bus.din = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
      chk("rst_zero", 32'(bus.zero), 32'd0);
      rst = 1'b0;
      run_word(1'b1, 8'h05, 8'hFB, 1'b0, 1'b0);
      @(posedge clk);
      #2 bus.start = 1'b1; bus.neg_en = 1'b1; bus.din = 8'h33;
      @(posedge clk);
      #2 bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_dout", 32'(bus.dout), 32'd0);
      chk("arst_ovf", 32'(bus.ovf), 32'd0);
      chk("arst_zero", 32'(bus.zero), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      run_word(1'b1, 8'h80, 8'h80, 1'b1, 1'b0);
      run_word(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
      run_word(1'b0, 8'hA6, 8'hA6, 1'b0, 1'b0);
      run_word(1'b1, 8'hA6, 8'h5A, 1'b0, 1'b0);
      ndone = 0;
      for (int i = 0; i < 41; i++) begin
         @(posedge clk);
         #2 bus.start = 1'b1; bus.neg_en = 1'b1; bus.din = W'(i + 1);
         @(negedge clk);
         if (bus.done) begin
            ndone++;
            if (ndone == 1) chk("cont_first", 32'(bus.dout), 32'hFF);
            if (ndone == 2) chk("cont_second", 32'(bus.dout), 32'hF5);
         end
      end
      chk("cont_count", 32'(ndone), 32'd4);
      @(posedge clk);
      #2 bus.start = 1'b0;
      repeat (W + 4) @(posedge clk);
      for (int n = 0; n < 2; n++)
         for (int d = 0; d < 256; d++)
            run_word(n[0], W'(d), n[0] ? W'(256 - d) : W'(d), n[0] && d == 8'h80, d == 0);
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
